clk_div_sequencer: RTL

Run-time controller for a programmable integer clock divider. Owns the divide ratio, start/stop and ratio-change sequencing, and emits a divided clock plus a one-cycle tick strobe. Ratio changes take effect only on a period boundary, so the output never glitches or produces short pulses. It sits between the config/CSR logic and any block clocked or enabled by the divided clock.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_core.sv | 77 +++++++
 rtl/clk_div_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider sequencer: FSM state encoding,
// the minimum legal divide ratio, and the ratio clamp helper.
package clk_div_pkg;

  // Legacy-compatible raw encodings; the enum below is built on them.
  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef enum logic [1:0] {
    STOP = ST_STOP,
    RUN  = ST_RUN,
    PEND = ST_PEND
  } state_e;

  // Smallest ratio that still yields a real high and low phase.
  localparam int unsigned MIN_DIV = 2;

  // Ratios 0 and 1 are meaningless for a divider; lift them to MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? 32'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock generation. The FSM above decides when
// the divider runs and which ratio applies; this block only counts.
// Optional build macro: CLKDIV_NEGEDGE_DUTY_EN adds a negedge flop that
// stretches odd ratios to an exact 50% duty cycle.
module clk_div_core #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,             // synchronous, active-low
  input  logic             run_i,           // divider running this cycle
  input  logic             run_next_i,      // divider running next cycle
  input  logic [CNT_W-1:0] cur_div_i,       // ratio in effect this cycle
  input  logic [CNT_W-1:0] cur_div_next_i,  // ratio in effect next cycle
  output logic             tick_o,
  output logic             clk_out_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_q, pos_d;
  logic [CNT_W:0]   high_len;
  logic             at_last;

  assign at_last = (cnt_q == (cur_div_i - CNT_W'(1)));
  assign tick_o  = run_i && at_last;

  // Next count: advance and wrap while running on both sides of the edge,
  // otherwise park at zero so a restart always begins a fresh period.
  always_comb begin
    cnt_d = '0;
    if (run_i && run_next_i && !at_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // High-phase length, one bit wider than the ratio so the max ratio fits.
  always_comb begin
`ifdef CLKDIV_NEGEDGE_DUTY_EN
    // floor(div/2) on posedge; the negedge copy adds the missing half cycle.
    high_len = {1'b0, cur_div_next_i} >> 1;
`else
    // ceil(div/2) cycles high.
    high_len = ({1'b0, cur_div_next_i} + (CNT_W+1)'(1)) >> 1;
`endif
    pos_d = run_next_i && ({1'b0, cnt_d} < high_len);
  end

  // Counter and posedge clock register; compare uses next-cycle values so
  // the registered clock lines up with the count held in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

`ifdef CLKDIV_NEGEDGE_DUTY_EN
  logic neg_q;

  // Half-cycle delayed copy of the posedge phase for odd-ratio duty fix.
  always_ff @(negedge clk) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Odd ratios OR in the delayed copy; gated so STOP reads low at once.
  assign clk_out_o = pos_q | (neg_q & cur_div_i[0] & run_i);
`else
  assign clk_out_o = pos_q;
`endif

endmodule

// File: rtl/clk_div_sequencer.sv
// Run-time controller for a programmable integer clock divider: owns the
// ratio, start/stop and boundary-aligned ratio changes.
// Optional build macro: CLKDIV_NEGEDGE_DUTY_EN (exact 50% duty for odd
// ratios, implemented inside clk_div_core).
module clk_div_sequencer
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = 3   // legal range 2 .. 2**CNT_W-1
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             tick,
  output logic             clk_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cfg_div_clamped;
  logic             xfer;
  logic             tick_int;

  assign cfg_div_clamped = CNT_W'(clamp_div(32'(cfg_div)));
  assign cfg_ready       = (state_q != PEND);
  assign busy            = (state_q == PEND);
  assign xfer            = cfg_valid && cfg_ready;
  assign cur_div         = cur_div_q;
  assign tick            = tick_int;

  // Sequencing: ratio changes while running wait in PEND for a tick;
  // dropping enable always wins and lands any pending ratio immediately.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    case (state_q)
      STOP: begin
        if (xfer) cur_div_d = cfg_div_clamped;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = STOP;
        end else if (xfer) begin
          pend_div_d = cfg_div_clamped;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          cur_div_d = pend_div_q;
          state_d   = STOP;
        end else if (tick_int) begin
          cur_div_d = pend_div_q;
          state_d   = RUN;
        end
      end
      default: state_d = STOP;
    endcase
  end

  // State and ratio registers; reset discards any pending change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= STOP;
      cur_div_q  <= CNT_W'(DEFAULT_DIV);
      pend_div_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .run_i         (state_q != STOP),
    .run_next_i    (state_d != STOP),
    .cur_div_i     (cur_div_q),
    .cur_div_next_i(cur_div_d),
    .tick_o        (tick_int),
    .clk_out_o     (clk_out)
  );

endmodule
